player_hit_ctrl: RTL
====================

// Module: player_hit_ctrl
// PURPOSE
//   Hit/lives controller feeding the player sprite stage. Watches per-pixel overlap of the
//   player sprite with enemy bullets or enemies during each video frame. Applies hits once per
//   frame and runs death, invulnerability and flashing timers. Drives the player's hit-sprite
//   select, visibility, lives count and game-over to the sprite mixer and score/HUD logic.
// PARAMETERS
//   LIVES_INIT     3    lives after reset/restart (1..7)
//   DEATH_FRAMES   60   frames spent in HIT (hit sprite shown, no movement credit)
//   INVULN_FRAMES  120  frames of invulnerability after HIT
//   FLASH_PERIOD   8    frames per visible/invisible phase while invulnerable (power of 2)
// PORTS
//   clk             in   1   pixel-domain clock
//   reset           in   1   synchronous, active-high
//   frame_start     in   1   1-cycle pulse, first pixel of each frame
//   player_on       in   1   player sprite opaque at current pixel
//   ebullet_on      in   1   enemy bullet opaque at current pixel
//   enemy_on        in   1   enemy sprite opaque at current pixel
//   restart         in   1   1-cycle pulse; honoured only in GAME_OVER
//   hit_sprite      out  1   1 = player stage shows hit sprite
//   player_visible  out  1   0 = mixer suppresses player pixels
//   invincible      out  1   1 in HIT and INVULN
//   lives           out  3   remaining lives
//   hit_pulse       out  1   1-cycle strobe when a hit is accepted
//   game_over       out  1   level, 1 in GAME_OVER
// BEHAVIOUR
//   Reset (sync, overrides everything incl. mid-timer): state=ALIVE, lives=LIVES_INIT,
//     frame_cnt=0, overlap_flag=0, hit_sprite=0, player_visible=1, invincible=0,
//     hit_pulse=0, game_over=0.
//   Overlap latch: overlap_flag sets on any cycle with player_on & (ebullet_on | enemy_on).
//     It clears on frame_start. An overlap on the frame_start cycle itself counts toward
//     the frame just ending (hit = overlap_flag | overlap_now).
//   Hit evaluation happens only on frame_start cycles. All outputs are registered, so a
//     change is visible the cycle after frame_start (latency 1).
//   FSM (advances only on frame_start unless noted):
//     ALIVE:     on hit -> HIT, lives<=lives-1, hit_pulse=1 (one cycle), frame_cnt<=0.
//     HIT:       overlaps ignored; hit_sprite=1, player_visible=1. frame_cnt++ per frame.
//                When frame_cnt==DEATH_FRAMES-1: -> GAME_OVER if lives==0, else
//                -> INVULN with frame_cnt<=0.
//     INVULN:    overlaps ignored; hit_sprite=0.
//                player_visible = ((frame_cnt/FLASH_PERIOD) even).
//                When frame_cnt==INVULN_FRAMES-1 -> ALIVE.
//     GAME_OVER: game_over=1, player_visible=0, lives=0. A restart pulse on any cycle ->
//                ALIVE next cycle with lives=LIVES_INIT, frame_cnt=0, overlap_flag=0.
//                Restart in other states is ignored.
//   lives never underflows. Decrement occurs only in ALIVE with lives>=1.
//   frame_cnt is wide enough for max(DEATH_FRAMES, INVULN_FRAMES) and saturates, never wraps.
//   frame_start and restart on the same cycle in GAME_OVER: restart wins. Overlap evaluation
//     starts with the next frame.
// TESTING
//   1 Reset, 5 frames, no overlap -> lives=3, player_visible=1, hit_pulse never asserted.
//   2 Overlap pixel in frame 2 -> at next frame_start+1: hit_pulse=1 for 1 cycle, lives=2,
//     hit_sprite=1. After 60 frames: hit_sprite=0, invincible=1. After 120 more frames:
//     invincible=0.
//   3 Overlap on every pixel during INVULN and HIT -> no extra hit_pulse, lives stays 2.
//     player_visible toggles every 8 frames (1 for frames 0-7, 0 for 8-15, ...).
//   4 Three hits with full timers -> lives=0. After third DEATH period: game_over=1,
//     player_visible=0. Pulse restart -> next cycle lives=3, game_over=0, state ALIVE.
//   5 Overlap only on the frame_start cycle -> counted as a hit for the ending frame.
//     Many overlaps in one frame -> exactly one hit_pulse.
//   6 Assert reset at frame 30 of HIT -> next cycle all outputs equal reset values,
//     lives=3.

Source files
------------

// File: rtl/player_hit_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : player_hit_ctrl                                                |
// | Brief   : Per-frame overlap latch, lives and death/invuln/flash timers.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module player_hit_ctrl #(
   parameter int LIVES_INIT    = 3,
   parameter int DEATH_FRAMES  = 60,
   parameter int INVULN_FRAMES = 120,
   parameter int FLASH_PERIOD  = 8
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       frame_start_i,
   input  logic       player_on_i,
   input  logic       ebullet_on_i,
   input  logic       enemy_on_i,
   input  logic       restart_i,
   output logic       hit_sprite_o,
   output logic       player_visible_o,
   output logic       invincible_o,
   output logic [2:0] lives_o,
   output logic       hit_pulse_o,
   output logic       game_over_o
);

   localparam int c_MAX_FRAMES = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
   localparam int c_CNT_W      = (c_MAX_FRAMES > 1) ? $clog2(c_MAX_FRAMES) : 1;
   localparam int c_FLASH_SH   = $clog2(FLASH_PERIOD);
   localparam logic [c_CNT_W-1:0] c_DEATH_LAST  = c_CNT_W'(DEATH_FRAMES - 1);
   localparam logic [c_CNT_W-1:0] c_INVULN_LAST = c_CNT_W'(INVULN_FRAMES - 1);
   localparam logic [2:0]         c_LIVES_INIT  = 3'(LIVES_INIT);

   typedef enum logic [1:0] {
      S_ALIVE     = 2'd0,
      S_HIT       = 2'd1,
      S_INVULN    = 2'd2,
      S_GAME_OVER = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [c_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [2:0]         lives_q, lives_d;
   logic               overlap_q, overlap_d;
   logic               hit_pulse_q, hit_pulse_d;
   logic               hit_sprite_q, hit_sprite_d;
   logic               visible_q, visible_d;
   logic               invincible_q, invincible_d;
   logic               game_over_q, game_over_d;

   logic               overlap_now;
   logic               hit_now;
   logic [c_CNT_W-1:0] cnt_inc;

   // An overlap on the frame_start cycle belongs to the frame that is ending.
   assign overlap_now = player_on_i & (ebullet_on_i | enemy_on_i);
   assign hit_now     = overlap_q | overlap_now;
   assign cnt_inc     = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + c_CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      lives_d     = lives_q;
      hit_pulse_d = 1'b0;
      overlap_d   = frame_start_i ? 1'b0 : hit_now;

      case (state_q)
         S_ALIVE: begin
            if (frame_start_i && hit_now && (lives_q != 3'd0)) begin
               state_d     = S_HIT;
               lives_d     = lives_q - 3'd1;
               hit_pulse_d = 1'b1;
               frame_cnt_d = '0;
            end
         end
         S_HIT: begin
            if (frame_start_i) begin
               if (frame_cnt_q == c_DEATH_LAST) begin
                  frame_cnt_d = '0;
                  state_d     = (lives_q == 3'd0) ? S_GAME_OVER : S_INVULN;
               end else begin
                  frame_cnt_d = cnt_inc;
               end
            end
         end
         S_INVULN: begin
            if (frame_start_i) begin
               if (frame_cnt_q == c_INVULN_LAST) begin
                  frame_cnt_d = '0;
                  state_d     = S_ALIVE;
               end else begin
                  frame_cnt_d = cnt_inc;
               end
            end
         end
         S_GAME_OVER: begin
            lives_d = 3'd0;
            // Restart beats a coincident frame_start; the new game starts with a clean latch.
            if (restart_i) begin
               state_d     = S_ALIVE;
               lives_d     = c_LIVES_INIT;
               frame_cnt_d = '0;
               overlap_d   = 1'b0;
            end
         end
         default: state_d = S_ALIVE;
      endcase

      hit_sprite_d = (state_d == S_HIT);
      invincible_d = (state_d == S_HIT) || (state_d == S_INVULN);
      game_over_d  = (state_d == S_GAME_OVER);
      case (state_d)
         S_INVULN:    visible_d = ((32'(frame_cnt_d) >> c_FLASH_SH) & 32'd1) == 32'd0;
         S_GAME_OVER: visible_d = 1'b0;
         default:     visible_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= S_ALIVE;
         frame_cnt_q  <= '0;
         lives_q      <= c_LIVES_INIT;
         overlap_q    <= 1'b0;
         hit_pulse_q  <= 1'b0;
         hit_sprite_q <= 1'b0;
         visible_q    <= 1'b1;
         invincible_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         lives_q      <= lives_d;
         overlap_q    <= overlap_d;
         hit_pulse_q  <= hit_pulse_d;
         hit_sprite_q <= hit_sprite_d;
         visible_q    <= visible_d;
         invincible_q <= invincible_d;
         game_over_q  <= game_over_d;
      end
   end

   assign hit_sprite_o     = hit_sprite_q;
   assign player_visible_o = visible_q;
   assign invincible_o     = invincible_q;
   assign lives_o          = lives_q;
   assign hit_pulse_o      = hit_pulse_q;
   assign game_over_o      = game_over_q;

endmodule
`default_nettype wire
